user_input_events: RTL and testbench

Parametrised front-panel input block: N quadrature encoders plus M push buttons are synchronised, decoded and debounced, and each change becomes a 32-bit event in a FIFO. The FIFO drains to the control CPU over a stb/ack input stream. It runs in the 50 MHz CPU clock domain and replaces polling of raw encoder position and button lines. A parallel position bus is kept for software that polls.

---
 rtl/user_input_pkg.sv | 28 ++
 rtl/user_input_quad.sv | 84 ++++++++
 rtl/user_input_events.sv | 180 ++++++++++++++++++
 tb/tb_user_input_events.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/user_input_pkg.sv
// rtl/user_input_pkg.sv - shared event types, field positions and position width for user_input_events
package user_input_pkg;

    localparam int POS_W = 16;

    localparam logic [1:0] EV_ENC     = 2'b00;
    localparam logic [1:0] EV_PRESS   = 2'b01;
    localparam logic [1:0] EV_RELEASE = 2'b10;
    localparam logic [1:0] EV_OVF     = 2'b11;

    localparam int EV_TYPE_MSB = 31;
    localparam int EV_TYPE_LSB = 30;
    localparam int EV_CHAN_MSB = 29;
    localparam int EV_CHAN_LSB = 24;
    localparam int EV_PAY_MSB  = 15;

    function automatic logic [31:0] make_event(input logic [1:0] ev_type,
                                               input logic [5:0] chan,
                                               input logic [15:0] payload);
        logic [31:0] ev;
        ev = '0;
        ev[EV_TYPE_MSB:EV_TYPE_LSB] = ev_type;
        ev[EV_CHAN_MSB:EV_CHAN_LSB] = chan;
        ev[EV_PAY_MSB:0]            = payload;
        return ev;
    endfunction

endpackage

// File: rtl/user_input_quad.sv
// rtl/user_input_quad.sv - one quadrature encoder channel; USER_INPUT_DETENT_EN selects per-detent counting
module user_input_quad
    import user_input_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             quad_a,
    input  logic             quad_b,
    input  logic             clr,
    output logic [POS_W-1:0] position,
    output logic             pending
);

    logic [1:0] ab_s1, ab_s2, ab_cur, ab_prev;
    logic       primed;
    logic       dir_up, dir_dn;
    logic       step_up, step_dn;

    // Two-flop synchroniser plus sample register; left unreset so live levels flow through reset
    always_ff @(posedge clk) begin
        ab_s1  <= {quad_a, quad_b};
        ab_s2  <= ab_s1;
        ab_cur <= ab_s2;
    end

    // Gray-step direction between consecutive samples; double-bit changes fall to default
    always_comb begin
        dir_up = 1'b0;
        dir_dn = 1'b0;
        if (primed) begin
            case ({ab_prev, ab_cur})
                4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: dir_up = 1'b1;
                4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: dir_dn = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef USER_INPUT_DETENT_EN
    logic signed [3:0] detent_acc, detent_sum;

    // A detent counts only when four same-direction sub-steps land back on AB=11
    always_comb begin
        detent_sum = detent_acc + (dir_up ? 4'sd1 : (dir_dn ? -4'sd1 : 4'sd0));
        step_up    = (ab_cur == 2'b11) && (detent_sum == 4'sd4);
        step_dn    = (ab_cur == 2'b11) && (detent_sum == -4'sd4);
    end

    // Sub-step accumulator restarts at every rest position so reversed partial moves cancel
    always_ff @(posedge clk) begin
        if (!rst_n)
            detent_acc <= '0;
        else if (ab_cur == 2'b11)
            detent_acc <= '0;
        else
            detent_acc <= detent_sum;
    end
`else
    assign step_up = dir_up;
    assign step_dn = dir_dn;
`endif

    // Position and pending flag; a fresh step outranks the arbiter clear so no motion is lost
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            primed   <= 1'b0;
            ab_prev  <= '0;
            position <= '0;
            pending  <= 1'b0;
        end else begin
            primed  <= 1'b1;
            ab_prev <= ab_cur;
            if (step_up)
                position <= position + POS_W'(1);
            else if (step_dn)
                position <= position - POS_W'(1);
            if (step_up || step_dn)
                pending <= 1'b1;
            else if (clr)
                pending <= 1'b0;
        end
    end

endmodule

// File: rtl/user_input_events.sv
// rtl/user_input_events.sv - encoder/button event block: debounce, priority arbiter, staging register and FWFT FIFO
module user_input_events
    import user_input_pkg::*;
#(
    parameter int NUM_ENCODERS      = 1,
    parameter int NUM_BUTTONS       = 5,
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int FIFO_DEPTH        = 8,
    parameter int BUTTON_ACTIVE_LOW = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_ENCODERS-1:0]   quad_a,
    input  logic [NUM_ENCODERS-1:0]   quad_b,
    input  logic [NUM_BUTTONS-1:0]    buttons,
    output logic [31:0]               event_out,
    output logic                      event_out_stb,
    input  logic                      event_out_ack,
    output logic [16*NUM_ENCODERS-1:0] position_out,
    output logic                      overflow
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;

    logic [POS_W-1:0]        enc_pos [NUM_ENCODERS];
    logic [NUM_ENCODERS-1:0] enc_pend, enc_clr;

    for (genvar k = 0; k < NUM_ENCODERS; k++) begin : g_enc
        user_input_quad u_quad (
            .clk      (clk),
            .rst_n    (rst_n),
            .quad_a   (quad_a[k]),
            .quad_b   (quad_b[k]),
            .clr      (enc_clr[k]),
            .position (enc_pos[k]),
            .pending  (enc_pend[k])
        );
        assign position_out[16*k +: 16] = enc_pos[k];
    end

    logic [NUM_BUTTONS-1:0] btn_s1, btn_s2, btn_s3, btn_level;
    logic [CNT_W-1:0]       db_cnt [NUM_BUTTONS];
    logic [NUM_BUTTONS-1:0] db_state, btn_toggle, btn_pend, btn_kind, btn_clr;
    logic [3:0]             drops;
    logic [15:0]            drop_cnt;
    logic [16:0]            drop_sum;
    logic                   ovf_clr;

    logic                   grant;
    logic [31:0]            grant_event;
    logic                   stage_valid;
    logic [31:0]            stage_data;
    logic [31:0]            fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]          fifo_wptr, fifo_rptr;
    logic [CW-1:0]          fifo_count;
    logic                   fifo_rd, fifo_room;

    // Button synchroniser plus sample register, unreset like the encoder chains
    always_ff @(posedge clk) begin
        btn_s1 <= buttons;
        btn_s2 <= btn_s1;
        btn_s3 <= btn_s2;
    end

    assign btn_level = (BUTTON_ACTIVE_LOW != 0) ? ~btn_s3 : btn_s3;

    // Debounce expiry and drops: a change landing on a still-pending flag overwrites it
    always_comb begin
        btn_toggle = '0;
        drops      = '0;
        for (int b = 0; b < NUM_BUTTONS; b++) begin
            btn_toggle[b] = (btn_level[b] != db_state[b]) &&
                            (db_cnt[b] == CNT_W'(DEBOUNCE_CYCLES - 1));
            if (btn_toggle[b] && btn_pend[b] && !btn_clr[b])
                drops = drops + 4'd1;
        end
        drop_sum = {1'b0, (ovf_clr ? 16'd0 : drop_cnt)} + 17'(drops);
    end

    // Per-button stable-time counter, debounced state and pending press/release flag
    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BUTTONS; b++) begin
            if (!rst_n) begin
                db_cnt[b]   <= '0;
                db_state[b] <= 1'b0;
                btn_pend[b] <= 1'b0;
                btn_kind[b] <= 1'b0;
            end else begin
                if (btn_level[b] == db_state[b] || btn_toggle[b])
                    db_cnt[b] <= '0;
                else
                    db_cnt[b] <= db_cnt[b] + CNT_W'(1);
                if (btn_toggle[b]) begin
                    db_state[b] <= ~db_state[b];
                    btn_pend[b] <= 1'b1;
                    btn_kind[b] <= ~db_state[b];
                end else if (btn_clr[b]) begin
                    btn_pend[b] <= 1'b0;
                end
            end
        end
    end

    // Saturating drop count for the marker payload; overflow is sticky until reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            if (drops != 4'd0)
                overflow <= 1'b1;
        end
    end

    assign fifo_rd   = event_out_stb && event_out_ack;
    // The staging slot counts against capacity so a granted event always finds room
    assign fifo_room = (fifo_count + CW'(stage_valid)) < (CW'(FIFO_DEPTH) + CW'(fifo_rd));

    // Fixed-priority grant: overflow marker, encoders ascending, then buttons ascending
    always_comb begin
        grant       = 1'b0;
        grant_event = '0;
        ovf_clr     = 1'b0;
        enc_clr     = '0;
        btn_clr     = '0;
        if (fifo_room) begin
            if (drop_cnt != 16'd0) begin
                grant       = 1'b1;
                ovf_clr     = 1'b1;
                grant_event = make_event(EV_OVF, 6'd0, drop_cnt);
            end
            for (int k = 0; k < NUM_ENCODERS; k++) begin
                if (!grant && enc_pend[k]) begin
                    grant       = 1'b1;
                    enc_clr[k]  = 1'b1;
                    grant_event = make_event(EV_ENC, 6'(k), enc_pos[k]);
                end
            end
            for (int b = 0; b < NUM_BUTTONS; b++) begin
                if (!grant && btn_pend[b]) begin
                    grant       = 1'b1;
                    btn_clr[b]  = 1'b1;
                    grant_event = make_event(btn_kind[b] ? EV_PRESS : EV_RELEASE, 6'(b), 16'd0);
                end
            end
        end
    end

    // Staging register and FIFO pointers; reset discards everything in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_valid <= 1'b0;
            stage_data  <= '0;
            fifo_wptr   <= '0;
            fifo_rptr   <= '0;
            fifo_count  <= '0;
        end else begin
            stage_valid <= grant;
            stage_data  <= grant_event;
            if (stage_valid)
                fifo_wptr <= fifo_wptr + AW'(1);
            if (fifo_rd)
                fifo_rptr <= fifo_rptr + AW'(1);
            fifo_count <= fifo_count + CW'(stage_valid) - CW'(fifo_rd);
        end
    end

    // FIFO storage write port
    always_ff @(posedge clk) begin
        if (stage_valid)
            fifo_mem[fifo_wptr] <= stage_data;
    end

    assign event_out_stb = (fifo_count != '0);
    assign event_out     = event_out_stb ? fifo_mem[fifo_rptr] : 32'd0;

endmodule

// File: tb/tb_user_input_events.sv
// tb/tb_user_input_events.sv - randomized directed bench for user_input_events against an event-level model
module tb_user_input_events;

    localparam int NE    = 2;
    localparam int NB    = 4;
    localparam int DC    = 16;
    localparam int DEPTH = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NE-1:0]      quad_a, quad_b;
    logic [NB-1:0]      buttons;
    logic [31:0]        event_out;
    logic               event_out_stb;
    logic               event_out_ack;
    logic [16*NE-1:0]   position_out;
    logic               overflow;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] got_q [$];
    logic [31:0] exp_q [$];

    logic [15:0] m_pos [NE];
    int          m_acc [NE];
    logic [1:0]  m_ab  [NE];
    logic        m_btn [NB];

    always #10 clk = ~clk;

    user_input_events #(
        .NUM_ENCODERS      (NE),
        .NUM_BUTTONS       (NB),
        .DEBOUNCE_CYCLES   (DC),
        .FIFO_DEPTH        (DEPTH),
        .BUTTON_ACTIVE_LOW (1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .quad_a        (quad_a),
        .quad_b        (quad_b),
        .buttons       (buttons),
        .event_out     (event_out),
        .event_out_stb (event_out_stb),
        .event_out_ack (event_out_ack),
        .position_out  (position_out),
        .overflow      (overflow)
    );

    always @(negedge clk) begin
        if (event_out_stb && event_out_ack)
            got_q.push_back(event_out);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int gray_idx(input logic [1:0] ab);
        case (ab)
            2'b00: return 0;
            2'b10: return 1;
            2'b11: return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] gray_ab(input int idx);
        case (idx)
            0: return 2'b00;
            1: return 2'b10;
            2: return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    function automatic logic [31:0] ev_word(input logic [1:0] t, input int ch, input logic [15:0] pay);
        return {t, 6'(ch), 8'h00, pay};
    endfunction

    task automatic enc_move(input int k, input int dir);
        logic [1:0] nab;
        nab = gray_ab((gray_idx(m_ab[k]) + dir + 4) % 4);
        quad_a[k] = nab[1];
        quad_b[k] = nab[0];
        m_ab[k]   = nab;
`ifdef USER_INPUT_DETENT_EN
        m_acc[k] = m_acc[k] + dir;
        if (nab == 2'b11) begin
            if (m_acc[k] == 4 || m_acc[k] == -4) begin
                m_pos[k] = m_pos[k] + 16'(m_acc[k] / 4);
                exp_q.push_back(ev_word(2'b00, k, m_pos[k]));
            end
            m_acc[k] = 0;
        end
`else
        m_pos[k] = m_pos[k] + 16'(dir);
        exp_q.push_back(ev_word(2'b00, k, m_pos[k]));
`endif
    endtask

    task automatic btn_drive(input int b, input logic pressed);
        buttons[b] = ~pressed;
    endtask

    task automatic btn_settle(input int b, input logic pressed);
        if (m_btn[b] != pressed)
            exp_q.push_back(ev_word(pressed ? 2'b01 : 2'b10, b, 16'h0000));
        m_btn[b] = pressed;
    endtask

    task automatic btn_change(input int b, input logic pressed);
        btn_drive(b, pressed);
        tick(DC + 8);
        btn_settle(b, pressed);
    endtask

    task automatic compare_events(input string tag);
        int n;
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_ev%0d", tag, i), got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic model_reset();
        for (int k = 0; k < NE; k++) begin
            m_pos[k] = 16'h0000;
            m_acc[k] = 0;
        end
        for (int b = 0; b < NB; b++)
            m_btn[b] = 1'b0;
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [31:0] ev_list [$];
        logic [31:0] pend_ev;
        int          n_chg, n_drop;
        logic        p;

        quad_a        = '1;
        quad_b        = '1;
        buttons       = '1;
        event_out_ack = 1'b1;
        rst_n         = 1'b0;
        for (int k = 0; k < NE; k++) m_ab[k] = 2'b11;
        model_reset();
        tick(5);
        rst_n = 1'b1;
        tick(2);

        check("reset_stb", 32'(event_out_stb), 32'd0);
        check("reset_event", event_out, 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset_position", position_out, 32'd0);

        // encoder 0: four A-leads-B transitions, first one timed edge by edge
        enc_move(0, 1);
        tick(3);
`ifndef USER_INPUT_DETENT_EN
        check("enc_pos_before_edge3", 32'(position_out[15:0]), 32'd0);
        tick(1);
        check("enc_pos_after_edge3", 32'(position_out[15:0]), 32'd1);
        tick(1);
        check("enc_stb_after_edge4", 32'(event_out_stb), 32'd0);
        tick(1);
        check("enc_stb_after_edge5", 32'(event_out_stb), 32'd1);
        check("enc_first_event", event_out, 32'h0000_0001);
`endif
        tick(6);
        for (int i = 0; i < 3; i++) begin
            enc_move(0, 1);
            tick($urandom_range(6, 10));
        end
        tick(15);
        compare_events("enc0_fwd");

        // encoder 1: one B-leads-A step wraps below zero
        enc_move(1, -1);
        tick(15);
        compare_events("enc1_wrap");
        check("enc1_position", 32'(position_out[31:16]), 32'(m_pos[1]));

        // random walk on both encoders
        for (int i = 0; i < 24; i++) begin
            enc_move($urandom_range(0, NE - 1), ($urandom_range(0, 1) != 0) ? 1 : -1);
            tick($urandom_range(6, 12));
        end
        tick(15);
        compare_events("enc_walk");
        for (int k = 0; k < NE; k++)
            check($sformatf("walk_pos%0d", k), 32'(position_out[16*k +: 16]), 32'(m_pos[k]));

        // button 2: three short bounces then a held press with timed latency
        for (int i = 0; i < 3; i++) begin
            btn_drive(2, 1'b1);
            tick($urandom_range(1, DC - 4));
            btn_drive(2, 1'b0);
            tick($urandom_range(2, 6));
        end
        btn_drive(2, 1'b1);
        tick(DC + 4);
        check("btn_stb_before", 32'(event_out_stb), 32'd0);
        tick(1);
        check("btn_stb_after", 32'(event_out_stb), 32'd1);
        check("btn_press_word", event_out, 32'h4200_0000);
        tick(10);
        btn_settle(2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            btn_drive(2, 1'b0);
            tick($urandom_range(1, DC - 4));
            btn_drive(2, 1'b1);
            tick($urandom_range(2, 6));
        end
        btn_change(2, 1'b0);
        tick(10);
        compare_events("btn2_bounce");

        // encoder 0 step and button 0 press reach pending on the same edge
        btn_drive(0, 1'b1);
        tick(DC - 1);
        enc_move(0, 1);
        tick(30);
        btn_settle(0, 1'b1);
        compare_events("same_cycle");

        btn_change(0, 1'b0);
        tick(5);
        compare_events("btn0_release");

        // overflow: stalled consumer, alternating button 0 changes
        event_out_ack = 1'b0;
        n_chg  = $urandom_range(5, 8);
        n_drop = 0;
        pend_ev = '0;
        ev_list.delete();
        for (int i = 0; i < n_chg; i++) begin
            p = ((i % 2) == 0);
            btn_drive(0, p);
            tick(DC + 8);
            if (i < DEPTH)
                ev_list.push_back(ev_word(p ? 2'b01 : 2'b10, 0, 16'h0000));
            else if (i == DEPTH)
                pend_ev = ev_word(p ? 2'b01 : 2'b10, 0, 16'h0000);
            else begin
                n_drop++;
                pend_ev = ev_word(p ? 2'b01 : 2'b10, 0, 16'h0000);
            end
            check($sformatf("stall_hold%0d", i), event_out, 32'h4000_0000);
            check($sformatf("stall_stb%0d", i), 32'(event_out_stb), 32'd1);
        end
        m_btn[0] = p;
        check("overflow_flag", 32'(overflow), (n_drop > 0) ? 32'd1 : 32'd0);
        for (int i = 0; i < ev_list.size(); i++) exp_q.push_back(ev_list[i]);
        if (n_drop > 0) exp_q.push_back(ev_word(2'b11, 0, 16'(n_drop)));
        exp_q.push_back(pend_ev);
        event_out_ack = 1'b1;
        tick(30);
        compare_events("overflow_drain");
        check("overflow_sticky", 32'(overflow), (n_drop > 0) ? 32'd1 : 32'd0);

        // reset while three events sit in the FIFO
        buttons = '1;
        for (int b = 0; b < NB; b++) m_btn[b] = 1'b0;
        tick(DC + 8);
        got_q.delete();
        exp_q.delete();
        event_out_ack = 1'b0;
        btn_change(1, 1'b1);
        btn_change(1, 1'b0);
        btn_change(1, 1'b1);
        check("pre_reset_stb", 32'(event_out_stb), 32'd1);
        rst_n   = 1'b0;
        buttons = '1;
        tick(1);
        check("mid_reset_stb", 32'(event_out_stb), 32'd0);
        check("mid_reset_event", event_out, 32'd0);
        check("mid_reset_position", position_out, 32'd0);
        check("mid_reset_overflow", 32'(overflow), 32'd0);
        tick(4);
        rst_n = 1'b1;
        model_reset();
        event_out_ack = 1'b1;
        tick(DC + 20);
        compare_events("post_reset");
        check("post_reset_position", position_out, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
